// File: rtl/pwm_ciclo_trabajo_multicanal.sv
// Multi-channel PWM generator with a shared prescaler and shadowed per-channel duty registers.
// Duty steps come from button press edges gated by chip_select; active duties reload only at wrap.
module pwm_ciclo_trabajo_multicanal #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DUTY_W    = 4,
  parameter int unsigned PRESC_DIV = 2,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DUTY_RST  = 8
) (
  input  logic                     clk_100MHz,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     down,
  input  logic [N_CH-1:0]          chip_select,
  output logic [N_CH-1:0]          signal_out,
  output logic [N_CH*DUTY_W-1:0]   ciclo_actual,
  output logic                     period_start
);

  localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRESC_W-1:0]       PrescLast = PRESC_W'(PRESC_DIV - 1);
  localparam logic [DUTY_W-1:0]        DutyMax   = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0]        CntLast   = DUTY_W'((2 ** DUTY_W) - 2);
  localparam logic [DUTY_W-1:0]        DutyRst   = DUTY_W'(DUTY_RST);
  localparam logic [DUTY_W:0]          StepU     = (DUTY_W + 1)'(STEP);
  localparam logic signed [DUTY_W+1:0] StepS     = $signed((DUTY_W + 2)'(STEP));

  logic [PRESC_W-1:0]             presc_q, presc_d;
  logic [DUTY_W-1:0]              cnt_q, cnt_d;
  logic [N_CH-1:0][DUTY_W-1:0]    shadow_q, shadow_d;
  logic [N_CH-1:0][DUTY_W-1:0]    active_q, active_d;
  logic [N_CH-1:0]                signal_out_q, signal_out_d;
  logic                           period_start_q, period_start_d;
  logic                           up_q, up_d;
  logic                           down_q, down_d;

  logic                           tick;
  logic                           wrap;
  logic                           press_up;
  logic                           press_dn;
  logic [N_CH-1:0][DUTY_W:0]      up_sum;
  logic signed [N_CH-1:0][DUTY_W+1:0] dn_diff;

  always_comb begin
    tick           = (presc_q == PrescLast);
    wrap           = tick && (cnt_q == CntLast);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    cnt_d          = cnt_q;
    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    period_start_d = wrap;
    up_d           = up;
    down_d         = down;
    press_up       = up & ~up_q;
    press_dn       = down & ~down_q;

    for (int i = 0; i < N_CH; i++) begin
      // Active duty samples the shadow before any press in this same cycle lands.
      active_d[i]     = wrap ? shadow_q[i] : active_q[i];
      signal_out_d[i] = (cnt_q < active_q[i]);
      up_sum[i]       = {1'b0, shadow_q[i]} + StepU;
      dn_diff[i]      = $signed({2'b00, shadow_q[i]}) - StepS;
      shadow_d[i]     = shadow_q[i];
      if (chip_select[i] && press_up && !press_dn) begin
        shadow_d[i] = (up_sum[i] > {1'b0, DutyMax}) ? DutyMax : up_sum[i][DUTY_W-1:0];
      end else if (chip_select[i] && press_dn && !press_up) begin
        shadow_d[i] = dn_diff[i][DUTY_W+1] ? '0 : dn_diff[i][DUTY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      shadow_q       <= {N_CH{DutyRst}};
      active_q       <= {N_CH{DutyRst}};
      signal_out_q   <= '0;
      period_start_q <= 1'b0;
      // Edge registers start high so a level held through reset is not a press.
      up_q           <= 1'b1;
      down_q         <= 1'b1;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      signal_out_q   <= signal_out_d;
      period_start_q <= period_start_d;
      up_q           <= up_d;
      down_q         <= down_d;
    end
  end

  assign signal_out   = signal_out_q;
  assign ciclo_actual = shadow_q;
  assign period_start = period_start_q;

endmodule

// File: doc/pwm_ciclo_trabajo_multicanal.md
Name: pwm_ciclo_trabajo_multicanal

Overview:
Parametrised successor to the single-channel duty-cycle modifier. Drives N_CH independent PWM outputs from one 100 MHz clock. An internal prescaler replaces the external work clock. Each channel's duty is stepped up/down by shared push-button pulses, gated by a per-channel chip_select. Duty changes are shadowed and applied only at period wrap, so the outputs are glitch-free. Sits between the debounced button logic and the motor/LED drivers.

Parameters:
N_CH, 4, number of PWM channels
DUTY_W, 4, duty/counter width; duty range 0..2^DUTY_W-1
PRESC_DIV, 2, clk_100MHz cycles per PWM tick (>=1; 1 = tick every cycle)
STEP, 1, duty increment/decrement per accepted press
DUTY_RST, 8, duty of every channel after reset (must be <= 2^DUTY_W-1)

Ports:
clk_100MHz  in  1  sole clock, rising edge
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on clk_100MHz rising edge)
up  in  1  increment request, level; debounced upstream
down  in  1  decrement request, level; debounced upstream
chip_select  in  N_CH  per-channel enable for up/down; any combination of bits may be set
signal_out  out  N_CH  PWM outputs, registered
ciclo_actual  out  N_CH*DUTY_W  requested (shadow) duty per channel; channel i occupies bits [i*DUTY_W +: DUTY_W]
period_start  out  1  one-cycle pulse on the cycle the active duties reload

Behaviour:
- Reset (rst=0 at an edge): prescaler=0; period counter cnt=0; shadow duty and active duty = DUTY_RST for all channels; signal_out=0; period_start=0; up/down edge registers = 1, so a level still held at reset release is not counted as a press. Reset mid-period aborts the period immediately.
- Prescaler: counts 0..PRESC_DIV-1. tick=1 on the cycle it equals PRESC_DIV-1, then it wraps to 0.
- Period counter: advances on tick, counting 0..MAX-1 with MAX=2^DUTY_W-1, then wraps to 0. Period = MAX*PRESC_DIV clocks (30 clocks at defaults).
- Wrap: on the tick where cnt=MAX-1, all active duties load from shadow and period_start pulses on the following cycle (the first cycle with cnt=0).
- Output: signal_out[i] is registered (cnt < active_duty[i]), one clock of latency. Duty 0 gives a constant 0. Duty MAX gives a constant 1.
- Press detection: press_up = up & ~up_q and press_dn = down & ~down_q, where up_q and down_q are the previous-cycle values.
- Press with up and down in the same cycle: both ignored.
- press_up only: every channel with chip_select[i]=1 updates shadow = min(shadow+STEP, MAX). Compute in DUTY_W+1 bits; no wrap-around.
- press_dn only: every channel with chip_select[i]=1 updates shadow = max(shadow-STEP, 0). Compute signed; no wrap-around.
- Shadow update latency: ciclo_actual reflects the new value on the cycle after the press edge is sampled.
- Press on the same cycle as the wrap load: the active duty takes the pre-press shadow; the new shadow applies at the next wrap.
- Deselected channels are never modified. chip_select=0 absorbs the press.

Test Plan:
- Reset release, defaults, no presses -> ciclo_actual = 0x8888; each signal_out is high 16 clocks, low 14, per 30-clock period; period_start pulses every 30 clocks.
- chip_select=4'b0001, up pulsed high for 50 ns (5 clk) -> ch0 shadow 8->9 (one step only), others unchanged; ch0 high time becomes 18 clocks from the next period_start, not before.
- chip_select=4'b0010, 10 down presses -> ch1 saturates at 0 (no wrap to 15); signal_out[1] stays constantly 0 from the next period on.
- chip_select=4'b1100, 10 up presses -> ch2 and ch3 saturate at 15; their signal_out stays constantly 1; ch0 and ch1 unchanged.
- up and down rising on the same cycle, chip_select=4'b1111 -> no channel changes.
- up held high while rst=0, then rst released -> no increment; rst pulled low mid-period with duty 12 -> next cycle signal_out=0, cnt=0, ciclo_actual=0x8888.
